vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing and pixel generator: accepts an hsync/vsync/12-bit RGB stream and recovers pixel coordinates from sync edges.
- Validates line and frame timing, locks onto it, and emits one frame-buffer write (address + RGB) per active pixel.
- Sits between a loop-back or camera video source and the frame-buffer BRAM that feeds the image-processing pipeline.
- Runs entirely on clock_100mhz; the pixel rate is set by a pixel_ce clock-enable strobe (1-in-4 for 25 MHz).

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel periods per line
- H_START, 144, h_cnt value of the first active pixel (sync 96 + back porch 48)
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- V_START, 35, v_cnt value of the first active line (sync 2 + back porch 33)
- ADDR_W, 19, write-address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clock_100mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_ce  in  1  pixel-rate enable; the video inputs are sampled only when it is high
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- rgb_in  in  12  pixel data {R[3:0], G[3:0], B[3:0]}
- wr_en  out  1  frame-buffer write strobe, one cycle wide
- wr_addr  out  ADDR_W  linear pixel address, y*H_ACTIVE+x
- wr_data  out  12  pixel written at wr_addr
- frame_start  out  1  one-cycle pulse at the start of each locked frame
- frame_done  out  1  one-cycle pulse with the last active-pixel write of a locked frame
- locked  out  1  timing lock status
- err_count  out  8  saturating count of timing errors seen while locked

Behaviour:
- Reset: every output is 0, FSM is in SEARCH, and all counters and sample registers are 0.
- Sampling: on each pixel_ce cycle, hsync_in, vsync_in and rgb_in are registered.
- Edge detection: a falling edge of a sync is the new sample at 0 while the previous sample is 1. Edges are evaluated only on pixel_ce cycles.
- h_cnt:
  - Loads 0 on an hsync falling edge; otherwise increments on every pixel_ce.
  - Saturates at 2047 and never wraps.
- v_cnt:
  - Loads 0 on a vsync falling edge; otherwise increments on each hsync falling edge.
  - If both edges occur on the same sample, the vsync rule wins and v_cnt is 0.
- Active pixel: H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE, with h_cnt and v_cnt taken as the counter values after the update for that sample.
- Line error: on an hsync falling edge, the pre-load h_cnt+1 is not equal to H_TOTAL. This check is skipped for the first edge after entering MEASURE.
- Frame error: on a vsync falling edge in MEASURE or LOCKED, the pre-load v_cnt+1 is not equal to V_TOTAL.
- FSM transitions:
  - SEARCH: on a vsync falling edge, go to MEASURE.
  - MEASURE: on a line error, go to SEARCH. On a vsync falling edge with no errors in the frame, go to LOCKED and pulse frame_start that cycle. On a vsync falling edge with a frame error, go to SEARCH.
  - LOCKED: on any line or frame error, go to SEARCH and increment err_count (saturates at 255). On a good vsync falling edge, pulse frame_start.
  - A line error and a frame error on the same sample count as one error.
- locked is 1 only while the FSM is in LOCKED.
- Write latency:
  - An active sample taken on pixel_ce cycle N while LOCKED produces wr_en=1 on cycle N+1.
  - On that cycle, wr_data holds the sampled rgb and wr_addr holds the running address.
  - wr_en is 0 at every other time.
- Address generation:
  - A running counter, with no multiplier.
  - Cleared to 0 with frame_start; increments after each write.
  - It is never allowed to exceed H_ACTIVE*V_ACTIVE-1; further active samples in that frame are dropped and counted as a timing error.
- frame_done coincides with the write to address H_ACTIVE*V_ACTIVE-1.
- Losing lock mid-frame: writes stop immediately; already-written pixels are not retracted.
- Asserting reset mid-frame returns the block to the full reset state on the next clock edge; no partial pulses appear.
- pixel_ce held low: the block holds all state, and no timeout applies.

Decomposition:
- vga_timing_pkg holds the 640x480 timing constants, the FSM state encoding (SEARCH, MEASURE, LOCKED) and the RGB width. The generator side reuses this package.
- One natural sub-module, vga_sync_detect: the sample registers, edge detectors, h_cnt/v_cnt, and the line/frame error flags.
- The FSM and address generation stay in vga_capture.

Test Plan:
- Standard 640x480 stream from the existing generator, pixel_ce 1-in-4:
  - locked rises at the second vsync fall, together with frame_start.
  - Next frame: exactly 307200 wr_en pulses with wr_addr 0..307199.
  - frame_done fires with addr 307199.
- Gradient rgb=(x^y)&12'hFFF: wr_data at address y*640+x matches the gradient for corners (0,0), (639,0), (0,479), (639,479) and one interior point.
- While locked, one line shortened to 799 pixels: locked falls at that hsync edge, err_count=1, no further writes; relock occurs two vsync edges later.
- Frame of 524 lines: SEARCH entered at the vsync fall, err_count increments, and no frame_start pulse on that edge.
- Assert reset at mid-frame line 200: all outputs 0 on the next edge; after release, the first frame_start arrives no earlier than the second vsync fall.
- hsync and vsync falling on the same sample: v_cnt=0, and the first write of the frame lands at addr 0 on line V_START.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, the capture FSM state encoding and the
// pixel width. Used by the capture block; the generator side imports it too.
package vga_timing_pkg;

  // 640x480 timing, in pixel periods and lines
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_H_START  = 144;  // hsync 96 + back porch 48
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_TOTAL  = 525;
  localparam int unsigned VGA_V_START  = 35;   // vsync 2 + back porch 33
  localparam int unsigned VGA_ADDR_W   = 19;   // 2^19 >= 640*480

  localparam int unsigned RGB_W = 12;          // {R[3:0], G[3:0], B[3:0]}
  localparam int unsigned CNT_W = 11;          // h/v counters, saturate at 2047

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vga_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_capture_sync_detect.sv
// Sync front end of the capture block: samples hsync/vsync/rgb on pixel_ce,
// detects falling sync edges, runs h_cnt/v_cnt and flags raw line/frame
// length errors. Whether an error matters is decided by the capture FSM.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   pixel_ce_i            pixel-rate enable; nothing changes when low
//   hsync_i, vsync_i      active-low syncs
//   rgb_i                 pixel data
//   hs_fall_o, vs_fall_o  falling edge seen on this pixel_ce sample
//   line_err_o            hsync edge with line length != H_TOTAL
//   frame_err_o           vsync edge with frame length != V_TOTAL
//   active_o              this sample is inside the active window
//   rgb_o                 registered rgb sample
module vga_capture_sync_detect
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned H_START  = VGA_H_START,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter int unsigned V_START  = VGA_V_START
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pixel_ce_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic [RGB_W-1:0] rgb_i,
  output logic             hs_fall_o,
  output logic             vs_fall_o,
  output logic             line_err_o,
  output logic             frame_err_o,
  output logic             active_o,
  output logic [RGB_W-1:0] rgb_o
);

  localparam logic [CNT_W-1:0] H_LO  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_HI  = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI  = CNT_W'(V_START + V_ACTIVE);
  localparam logic [CNT_W-1:0] H_TOT = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOT = CNT_W'(V_TOTAL);

  logic             hs_q, vs_q;
  logic [RGB_W-1:0] rgb_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    // Edge = new sample low while the previous sample register is high.
    hs_fall_o = pixel_ce_i & ~hsync_i & hs_q;
    vs_fall_o = pixel_ce_i & ~vsync_i & vs_q;

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pixel_ce_i) begin
      h_cnt_d = hs_fall_o ? '0 : sat_inc(h_cnt_q);
      // vsync wins when both edges land on the same sample
      if (vs_fall_o)      v_cnt_d = '0;
      else if (hs_fall_o) v_cnt_d = sat_inc(v_cnt_q);
    end

    // Length checks use the pre-load counts (last index + 1 = length).
    line_err_o  = hs_fall_o && ((h_cnt_q + CNT_W'(1)) != H_TOT);
    frame_err_o = vs_fall_o && ((v_cnt_q + CNT_W'(1)) != V_TOT);

    // Active window judged on the counts after this sample's update.
    active_o = pixel_ce_i &&
               (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
               (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      rgb_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (pixel_ce_i) begin
      hs_q    <= hsync_i;
      vs_q    <= vsync_i;
      rgb_q   <= rgb_i;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: locks onto an hsync/vsync/rgb stream and emits one
// frame-buffer write per active pixel while timing is locked.
//
// Write interface: wr_en is a one-cycle strobe qualifying wr_addr/wr_data on
// that same cycle. There is no back-pressure; the frame buffer must accept
// every strobe.
//
// Ports:
//   clock_100mhz, reset   clock, async active-high reset
//   pixel_ce              pixel-rate enable for the video inputs
//   hsync_in, vsync_in    active-low syncs
//   rgb_in                {R,G,B} 4 bits each
//   wr_en/wr_addr/wr_data frame-buffer write (addr = y*H_ACTIVE + x)
//   frame_start           pulse on each good vsync edge while locked
//   frame_done            pulse with the write of the last pixel
//   locked                FSM is in LOCKED
//   err_count             saturating count of errors seen while locked
//   dbg_state_o           current FSM state
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned H_START  = VGA_H_START,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter int unsigned V_START  = VGA_V_START,
  parameter int unsigned ADDR_W   = VGA_ADDR_W
) (
  input  logic              clock_100mhz,
  input  logic              reset,
  input  logic              pixel_ce,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              locked,
  output logic [7:0]        err_count,
  output vga_state_e        dbg_state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic hs_fall, vs_fall, line_err, frame_err, active;

  vga_capture_sync_detect #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .H_START  (H_START),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .V_START  (V_START)
  ) u_sync (
    .clk_i       (clock_100mhz),
    .rst_i       (reset),
    .pixel_ce_i  (pixel_ce),
    .hsync_i     (hsync_in),
    .vsync_i     (vsync_in),
    .rgb_i       (rgb_in),
    .hs_fall_o   (hs_fall),
    .vs_fall_o   (vs_fall),
    .line_err_o  (line_err),
    .frame_err_o (frame_err),
    .active_o    (active),
    .rgb_o       (wr_data)
  );

  vga_state_e        state_q, state_d;
  logic              skip_q, skip_d;     // ignore first line check in MEASURE
  logic [ADDR_W-1:0] addr_q, addr_d;     // next address to write
  logic              full_q, full_d;     // last address already written
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              fstart_q, fstart_d;
  logic              fdone_q, fdone_d;
  logic [7:0]        err_q, err_d;
  logic              err_hit, do_write;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    addr_d    = addr_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    fstart_d  = 1'b0;
    fdone_d   = 1'b0;
    err_d     = err_q;
    err_hit   = 1'b0;
    do_write  = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_MEASURE;
          skip_d  = 1'b1;
        end
      end
      ST_MEASURE: begin
        // The line that was in flight when MEASURE began is not judged.
        if (hs_fall) skip_d = 1'b0;
        if ((line_err && !skip_q) || frame_err) begin
          state_d = ST_SEARCH;
        end else if (vs_fall) begin
          state_d  = ST_LOCKED;
          fstart_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        // An active sample after the last address means the frame is too
        // long for the buffer; it is dropped and treated as a timing error.
        if (line_err || frame_err || (active && full_q)) begin
          state_d = ST_SEARCH;
          err_hit = 1'b1;
        end else begin
          if (vs_fall) fstart_d = 1'b1;
          if (active)  do_write = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (err_hit && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    if (fstart_d) begin
      addr_d = '0;
      full_d = 1'b0;
    end else if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      if (addr_q == LAST_ADDR) begin
        full_d  = 1'b1;
        fdone_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      skip_q    <= 1'b0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      fstart_q  <= 1'b0;
      fdone_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      fstart_q  <= fstart_d;
      fdone_q   <= fdone_d;
      err_q     <= err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign locked      = (state_q == ST_LOCKED);
  assign err_count   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced raster (8x4 active in 16x8 total) so
// whole frames stay short. Frames are described by a table; each row gives
// the frame shape and the expected FSM/lock/error view at its first sample
// and at its end. Pixel writes are checked through an expected queue.
module tb_vga_capture;
  import vga_timing_pkg::*;

  localparam int H_ACTIVE = 8;
  localparam int H_TOTAL  = 16;
  localparam int H_START  = 4;
  localparam int V_ACTIVE = 4;
  localparam int V_TOTAL  = 8;
  localparam int V_START  = 2;
  localparam int ADDR_W   = 19;
  localparam int H_SYNC   = 2;
  localparam int V_SYNC   = 1;
  localparam int LAST     = H_ACTIVE * V_ACTIVE - 1;
  localparam int EXP_W    = 1 + ADDR_W + RGB_W;   // {done, addr, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, pixel_ce, hsync_in, vsync_in;
  logic [RGB_W-1:0]  rgb_in;
  logic              wr_en, frame_start, frame_done, locked;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_data;
  logic [7:0]        err_count;
  vga_state_e        dbg_state;

  vga_capture #(
    .H_ACTIVE (H_ACTIVE), .H_TOTAL (H_TOTAL), .H_START (H_START),
    .V_ACTIVE (V_ACTIVE), .V_TOTAL (V_TOTAL), .V_START (V_START),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock_100mhz (clk),
    .reset        (reset),
    .pixel_ce     (pixel_ce),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .rgb_in       (rgb_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .locked       (locked),
    .err_count    (err_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int fd_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!reset && wr_en) begin
      wr_cnt++;
      chk("wr_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[RGB_W +: ADDR_W]));
        chk("wr_data", 32'(wr_data), 32'(e[RGB_W-1:0]));
        chk("frame_done_with_write", 32'(frame_done), 32'(e[EXP_W-1]));
      end
      if (frame_done) fd_cnt++;
    end else if (!reset && frame_done) begin
      chk("frame_done_without_write", 32'(frame_done), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // One pixel sample: mostly 1-in-4, occasionally a long pixel_ce-low hold.
  task automatic drive_sample(input logic hs, input logic vs, input logic [RGB_W-1:0] rgb);
    int gap;
    gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 40)) : 3;
    pixel_ce = 1'b0;
    repeat (gap) @(negedge clk);
    pixel_ce = 1'b1;
    hsync_in = hs;
    vsync_in = vs;
    rgb_in   = rgb;
    @(negedge clk);
    pixel_ce = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_wr_en"},       32'(wr_en),       32'd0);
    chk({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
    chk({tag, "_wr_data"},     32'(wr_data),     32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_frame_done"},  32'(frame_done),  32'd0);
    chk({tag, "_locked"},      32'(locked),      32'd0);
    chk({tag, "_err_count"},   32'(err_count),   32'd0);
    chk({tag, "_state"},       32'(dbg_state),   32'(ST_SEARCH));
  endtask

  typedef struct {
    int         lines;       // lines driven in this frame
    int         short_line;  // line driven one pixel short, -1 for none
    bit         exp_wr;      // frame is expected to be captured
    bit         rnd;         // random active pixels instead of the gradient
    vga_state_e st_start;    // expected after the first sample
    bit         lock_start;
    bit         fs_start;
    int         err_start;
    bit         lock_end;
    int         err_end;
  } frame_vec_t;

  task automatic run_frame(input int idx, input frame_vec_t v);
    int wr0, fd0, n_exp, plen, x, y;
    bit act;
    logic [RGB_W-1:0] rgb;
    wr0 = wr_cnt;
    fd0 = fd_cnt;
    n_exp = 0;
    for (int l = 0; l < v.lines; l++) begin
      plen = (l == v.short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int p = 0; p < plen; p++) begin
        act = (l >= V_START) && (l < V_START + V_ACTIVE) &&
              (p >= H_START) && (p < H_START + H_ACTIVE);
        x = p - H_START;
        y = l - V_START;
        rgb = RGB_W'($urandom_range(0, 4095));
        if (act && !v.rnd) rgb = RGB_W'((x ^ y) & 12'hFFF);
        if (act && v.exp_wr && (v.short_line < 0 || l <= v.short_line)) begin
          exp_q.push_back({(y * H_ACTIVE + x) == LAST, ADDR_W'(y * H_ACTIVE + x), rgb});
          n_exp++;
        end
        drive_sample(p >= H_SYNC, l >= V_SYNC, rgb);
        if (l == 0 && p == 0) begin
          chk($sformatf("f%0d_start_state", idx),  32'(dbg_state),   32'(v.st_start));
          chk($sformatf("f%0d_start_locked", idx), 32'(locked),      32'(v.lock_start));
          chk($sformatf("f%0d_frame_start", idx),  32'(frame_start), 32'(v.fs_start));
          chk($sformatf("f%0d_start_err", idx),    32'(err_count),   32'(v.err_start));
        end
        if (v.short_line >= 0 && l == v.short_line + 1 && p == 0) begin
          chk($sformatf("f%0d_shortline_locked", idx), 32'(locked),    32'd0);
          chk($sformatf("f%0d_shortline_err", idx),    32'(err_count), 32'(v.err_end));
        end
      end
    end
    chk($sformatf("f%0d_writes", idx),      32'(wr_cnt - wr0), 32'(n_exp));
    chk($sformatf("f%0d_frame_done", idx),  32'(fd_cnt - fd0),
        32'(v.exp_wr && v.short_line < 0 && v.lines >= V_START + V_ACTIVE));
    chk($sformatf("f%0d_queue_empty", idx), 32'(exp_q.size()), 32'd0);
    chk($sformatf("f%0d_end_locked", idx),  32'(locked),       32'(v.lock_end));
    chk($sformatf("f%0d_end_err", idx),     32'(err_count),    32'(v.err_end));
  endtask

  // ---------------- test ----------------
  frame_vec_t tbl[11];
  frame_vec_t post[3];

  initial begin
    //           lines short wr  rnd st_start    lk fs err lk_end err_end
    tbl[0]  = '{8, -1, 1'b0, 1'b0, ST_MEASURE, 1'b0, 1'b0, 0, 1'b0, 0};
    tbl[1]  = '{8, -1, 1'b1, 1'b0, ST_LOCKED,  1'b1, 1'b1, 0, 1'b1, 0};
    tbl[2]  = '{8, -1, 1'b1, 1'b1, ST_LOCKED,  1'b1, 1'b1, 0, 1'b1, 0};
    tbl[3]  = '{8,  4, 1'b1, 1'b0, ST_LOCKED,  1'b1, 1'b1, 0, 1'b0, 1};
    tbl[4]  = '{8, -1, 1'b0, 1'b0, ST_MEASURE, 1'b0, 1'b0, 1, 1'b0, 1};
    tbl[5]  = '{8, -1, 1'b1, 1'b1, ST_LOCKED,  1'b1, 1'b1, 1, 1'b1, 1};
    tbl[6]  = '{7, -1, 1'b1, 1'b0, ST_LOCKED,  1'b1, 1'b1, 1, 1'b1, 1};
    tbl[7]  = '{8, -1, 1'b0, 1'b0, ST_SEARCH,  1'b0, 1'b0, 2, 1'b0, 2};
    tbl[8]  = '{8, -1, 1'b0, 1'b0, ST_MEASURE, 1'b0, 1'b0, 2, 1'b0, 2};
    tbl[9]  = '{8, -1, 1'b1, 1'b1, ST_LOCKED,  1'b1, 1'b1, 2, 1'b1, 2};
    tbl[10] = '{4, -1, 1'b1, 1'b0, ST_LOCKED,  1'b1, 1'b1, 2, 1'b1, 2};
    // After a mid-frame reset: the first frame's edge is invisible (sample
    // registers cleared), so lock comes at the third source vsync edge.
    post[0] = '{8, -1, 1'b0, 1'b0, ST_SEARCH,  1'b0, 1'b0, 0, 1'b0, 0};
    post[1] = '{8, -1, 1'b0, 1'b0, ST_MEASURE, 1'b0, 1'b0, 0, 1'b0, 0};
    post[2] = '{8, -1, 1'b1, 1'b0, ST_LOCKED,  1'b1, 1'b1, 0, 1'b1, 0};

    reset    = 1'b1;
    pixel_ce = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in   = '0;
    repeat (3) @(negedge clk);
    check_reset_outs("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outs("rst_release");

    // Tail of a previous frame so the first vsync fall is visible.
    for (int i = 0; i < 4; i++) drive_sample(1'b1, 1'b1, RGB_W'($urandom_range(0, 4095)));

    foreach (tbl[i]) run_frame(i, tbl[i]);

    // Reset in the middle of the active area (row 10 stopped at line 3).
    reset    = 1'b1;
    pixel_ce = 1'b0;
    @(negedge clk);
    check_reset_outs("rst_mid");
    exp_q.delete();
    reset = 1'b0;

    foreach (post[i]) run_frame(20 + i, post[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
